mux_2to1_rr_arb: RTL and testbench



---
 rtl/mux_2to1_rr_arb.sv | 43 ++++
 tb/tb_mux_2to1_rr_arb.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mux_2to1_rr_arb.sv
// mux_2to1_rr_arb: two-source round-robin arbiter feeding a registered 2:1 data mux.
module mux_2to1_rr_arb #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [width-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [width-1:0] b_data,
  output logic             b_ready,
  output logic             c_valid,
  output logic [width-1:0] c_data,
  input  logic             c_ready,
  output logic             sel
);
  logic last;
  logic load;
  logic grant;
  // rst_n gates load so both readys stay low while reset is held
  always_comb begin
    load    = rst_n & (!c_valid | c_ready) & (a_valid | b_valid);
    grant   = (a_valid & b_valid) ? !last : b_valid;
    a_ready = load & !grant;
    b_ready = load & grant;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid <= 1'b0;
      c_data  <= '0;
      sel     <= 1'b0;
      last    <= 1'b1;
    end else if (load) begin
      c_valid <= 1'b1;
      c_data  <= grant ? b_data : a_data;
      sel     <= grant;
      last    <= grant;
    end else if (c_ready) begin
      c_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_2to1_rr_arb.sv
// tb_mux_2to1_rr_arb: directed vector table plus hand sequences for reset behaviour.
module tb_mux_2to1_rr_arb;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0, c_ready = 1'b0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_ready, b_ready, c_valid, sel;
  logic [7:0] c_data;
  int tests = 0;
  int fails = 0;

  mux_2to1_rr_arb #(.width(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .c_valid(c_valid), .c_data(c_data), .c_ready(c_ready),
    .sel(sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       cr;
    logic       ar;
    logic       br;
    logic       cv;
    logic [7:0] cd;
    logic       sl;
  } vec_t;

  vec_t v[21];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [7:0] ad, input logic bv,
                       input logic [7:0] bd, input logic cr);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; c_ready = cr;
  endtask

  initial begin
    v[0]  = '{1'b1, 8'hA0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0};
    v[1]  = '{1'b0, 8'h00, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB0, 1'b1};
    v[2]  = '{1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0};
    v[3]  = '{1'b1, 8'hA2, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB2, 1'b1};
    v[4]  = '{1'b1, 8'hA3, 1'b1, 8'hB3, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0};
    v[5]  = '{1'b1, 8'hA4, 1'b1, 8'hB4, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB4, 1'b1};
    v[6]  = '{1'b1, 8'hA5, 1'b1, 8'hB5, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
    v[7]  = '{1'b1, 8'hA6, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
    v[8]  = '{1'b1, 8'hA6, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
    v[9]  = '{1'b1, 8'hA6, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0};
    v[10] = '{1'b1, 8'hA6, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB0, 1'b1};
    v[11] = '{1'b1, 8'hA0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0};
    v[12] = '{1'b1, 8'hA1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0};
    v[13] = '{1'b1, 8'hA2, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b0};
    v[14] = '{1'b1, 8'hA3, 1'b1, 8'hB3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB3, 1'b1};
    v[15] = '{1'b0, 8'h00, 1'b1, 8'hB5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB5, 1'b1};
    v[16] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hB5, 1'b1};
    v[17] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hB5, 1'b1};
    v[18] = '{1'b1, 8'hA7, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA7, 1'b0};
    v[19] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA7, 1'b0};
    v[20] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA7, 1'b0};

    drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    #2;
    chk("rst_c_valid", {7'd0, c_valid}, 8'd0);
    chk("rst_c_data", c_data, 8'h00);
    chk("rst_sel", {7'd0, sel}, 8'd0);
    chk("rst_a_ready", {7'd0, a_ready}, 8'd0);
    chk("rst_b_ready", {7'd0, b_ready}, 8'd0);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(v[i].av, v[i].ad, v[i].bv, v[i].bd, v[i].cr);
      #1;
      chk($sformatf("v%0d_a_ready", i), {7'd0, a_ready}, {7'd0, v[i].ar});
      chk($sformatf("v%0d_b_ready", i), {7'd0, b_ready}, {7'd0, v[i].br});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_c_valid", i), {7'd0, c_valid}, {7'd0, v[i].cv});
      chk($sformatf("v%0d_c_data", i), c_data, v[i].cd);
      chk($sformatf("v%0d_sel", i), {7'd0, sel}, {7'd0, v[i].sl});
    end

    drive(1'b0, 8'h00, 1'b1, 8'hB9, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_c_valid", {7'd0, c_valid}, 8'd1);
    chk("pre_rst_c_data", c_data, 8'hB9);
    drive(1'b1, 8'hA9, 1'b1, 8'hB9, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_c_valid", {7'd0, c_valid}, 8'd0);
    chk("mid_rst_c_data", c_data, 8'h00);
    chk("mid_rst_sel", {7'd0, sel}, 8'd0);
    chk("mid_rst_a_ready", {7'd0, a_ready}, 8'd0);
    chk("mid_rst_b_ready", {7'd0, b_ready}, 8'd0);
    #3 rst_n = 1'b1;
    #1;
    chk("post_rst_a_ready", {7'd0, a_ready}, 8'd1);
    chk("post_rst_b_ready", {7'd0, b_ready}, 8'd0);
    @(posedge clk);
    #1;
    chk("post_rst_c_valid", {7'd0, c_valid}, 8'd1);
    chk("post_rst_c_data", c_data, 8'hA9);
    chk("post_rst_sel", {7'd0, sel}, 8'd0);
    #1;
    chk("post_rst_next_b_ready", {7'd0, b_ready}, 8'd1);
    @(posedge clk);
    #1;
    chk("post_rst_next_c_data", c_data, 8'hB9);
    chk("post_rst_next_sel", {7'd0, sel}, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
